// File: rtl/lvds_target_ctrl.sv
// Target-side frame controller for the LVDS remote-IO link: decodes 42-bit host
// command frames into register-bus strobes and returns 34-bit response/keepalive frames.
module lvds_target_ctrl #(
  parameter int unsigned KEEPALIVE    = 1024,
  parameter int unsigned READ_TIMEOUT = 256,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic        c,
  input  logic        r,
  input  logic [41:0] rx_d,
  input  logic        rx_v,
  output logic [33:0] tx_d,
  output logic        tx_v,
  input  logic        tx_rdy,
  output logic [6:0]  bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid,
  output logic [15:0] frame_cnt,
  output logic [7:0]  proto_err,
  output logic [7:0]  overrun_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    RESP      = 2'd2,
    KA_SEND   = 2'd3
  } state_t;

  localparam bit          KA_EN     = (KEEPALIVE != 0);
  localparam int unsigned IW        = (KEEPALIVE > 1) ? $clog2(KEEPALIVE) : 1;
  localparam int unsigned KA_LAST_I = KA_EN ? (KEEPALIVE - 1) : 0;
  localparam logic [IW-1:0] KA_LAST = KA_LAST_I[IW-1:0];
  localparam int unsigned RW        = $clog2(READ_TIMEOUT + 1);
  localparam logic [RW-1:0] RD_LAST = READ_TIMEOUT[RW-1:0];

  state_t        state, state_n;
  logic [IW-1:0] idle_cnt;
  logic [RW-1:0] rd_cnt;
  logic          frame_ok;
  logic          frame_bad;
  logic          is_read;
  logic          rd_hit;
  logic          rd_expire;
  logic          ka_fire;

  assign frame_ok  = rx_v && (rx_d[41:40] == 2'b00);
  assign frame_bad = rx_v && (rx_d[41:40] != 2'b00);
  assign is_read   = rx_d[39];

  // The response register is only valid in the two transmit states.
  assign tx_v = (state == RESP) || (state == KA_SEND);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    rd_hit    = 1'b0;
    rd_expire = 1'b0;
    ka_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (frame_ok && is_read) begin
          state_n = READ_WAIT;
        end else if (KA_EN && !rx_v && (idle_cnt == KA_LAST)) begin
          ka_fire = 1'b1;
          state_n = KA_SEND;
        end
      end
      READ_WAIT: begin
        // bus_re is only high on the first READ_WAIT cycle; data there is stale.
        if (bus_rvalid && !bus_re) begin
          rd_hit  = 1'b1;
          state_n = RESP;
        end else if (rd_cnt == RD_LAST) begin
          rd_expire = 1'b1;
          state_n   = RESP;
        end
      end
      RESP, KA_SEND: begin
        if (tx_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge c or negedge r) begin
    if (!r) state <= IDLE;
    else    state <= state_n;
  end

  // Register-bus strobes; they default low so each is a single-cycle pulse.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      bus_we <= 1'b0;
      bus_re <= 1'b0;
      if ((state == IDLE) && frame_ok) begin
        bus_addr <= rx_d[38:32];
        if (is_read) begin
          bus_re <= 1'b1;
        end else begin
          bus_we    <= 1'b1;
          bus_wdata <= rx_d[31:0];
        end
      end
    end
  end

  // Frame statistics: frame_cnt wraps, the error counters saturate.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      frame_cnt   <= '0;
      proto_err   <= '0;
      overrun_err <= '0;
    end else begin
      if ((state == IDLE) && frame_ok) frame_cnt <= frame_cnt + 16'd1;
      if (frame_bad && (proto_err != 8'hFF)) proto_err <= proto_err + 8'd1;
      if (frame_ok && (state != IDLE) && (overrun_err != 8'hFF))
        overrun_err <= overrun_err + 8'd1;
    end
  end

  // Idle and read-latency timers; both restart whenever their state is left.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      idle_cnt <= '0;
      rd_cnt   <= '0;
    end else begin
      if ((state == IDLE) && !rx_v && (state_n == IDLE)) idle_cnt <= idle_cnt + 1'b1;
      else                                               idle_cnt <= '0;
      if (state == READ_WAIT) rd_cnt <= rd_cnt + 1'b1;
      else                    rd_cnt <= '0;
    end
  end

  // Response frame is loaded on entry to RESP/KA_SEND and held until accepted.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      tx_d <= '0;
    end else if (rd_hit) begin
      tx_d <= {1'b0, 1'b0, bus_rdata};
    end else if (rd_expire) begin
      tx_d <= {1'b0, 1'b1, TIMEOUT_DATA};
    end else if (ka_fire) begin
      tx_d <= {1'b1, 1'b0, proto_err, overrun_err, frame_cnt};
    end
  end

endmodule

// File: tb/tb_lvds_target_ctrl.sv
// Directed self-checking bench for lvds_target_ctrl: one instance with keepalives
// disabled for bus/response checks, one with KEEPALIVE=16 for the keepalive cadence.
module tb_lvds_target_ctrl;

  logic        c = 1'b0;
  logic        r;

  logic [41:0] rx_d;
  logic        rx_v;
  logic [33:0] tx_d;
  logic        tx_v;
  logic        tx_rdy;
  logic [6:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;
  logic [15:0] frame_cnt;
  logic [7:0]  proto_err;
  logic [7:0]  overrun_err;

  logic [41:0] k_rx_d;
  logic        k_rx_v;
  logic [33:0] k_tx_d;
  logic        k_tx_v;
  logic        k_tx_rdy;
  logic [6:0]  k_bus_addr;
  logic [31:0] k_bus_wdata;
  logic        k_bus_we;
  logic        k_bus_re;
  logic [15:0] k_frame_cnt;
  logic [7:0]  k_proto_err;
  logic [7:0]  k_overrun_err;

  int passed = 0;
  int total  = 0;
  int tx_v_cycles = 0;
  int excl_viol   = 0;

  always #5 c = ~c;

  lvds_target_ctrl #(
    .KEEPALIVE   (0),
    .READ_TIMEOUT(20),
    .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .c          (c),
    .r          (r),
    .rx_d       (rx_d),
    .rx_v       (rx_v),
    .tx_d       (tx_d),
    .tx_v       (tx_v),
    .tx_rdy     (tx_rdy),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .bus_rvalid (bus_rvalid),
    .frame_cnt  (frame_cnt),
    .proto_err  (proto_err),
    .overrun_err(overrun_err)
  );

  lvds_target_ctrl #(
    .KEEPALIVE   (16),
    .READ_TIMEOUT(20),
    .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut_ka (
    .c          (c),
    .r          (r),
    .rx_d       (k_rx_d),
    .rx_v       (k_rx_v),
    .tx_d       (k_tx_d),
    .tx_v       (k_tx_v),
    .tx_rdy     (k_tx_rdy),
    .bus_addr   (k_bus_addr),
    .bus_wdata  (k_bus_wdata),
    .bus_we     (k_bus_we),
    .bus_re     (k_bus_re),
    .bus_rdata  (32'h0),
    .bus_rvalid (1'b0),
    .frame_cnt  (k_frame_cnt),
    .proto_err  (k_proto_err),
    .overrun_err(k_overrun_err)
  );

  // Mid-cycle monitors for response occupancy and strobe exclusivity.
  always @(negedge c) begin
    if (tx_v === 1'b1) tx_v_cycles++;
    if (bus_we === 1'b1 && bus_re === 1'b1) excl_viol++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("check %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Presents a frame for one cycle; returns one cycle later (cycle N+1).
  task automatic send(input logic [41:0] f);
    rx_d = f;
    rx_v = 1'b1;
    tick();
    rx_v = 1'b0;
  endtask

  initial begin
    r = 1'b0;
    rx_d = '0; rx_v = 1'b0; tx_rdy = 1'b1;
    bus_rdata = '0; bus_rvalid = 1'b0;
    k_rx_d = '0; k_rx_v = 1'b0; k_tx_rdy = 1'b1;
    repeat (3) @(posedge c);
    #1;
    check("rst_tx_v", {63'd0, tx_v}, 64'd0);
    check("rst_tx_d", {30'd0, tx_d}, 64'd0);
    check("rst_bus_we", {63'd0, bus_we}, 64'd0);
    check("rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
    r = 1'b1;

    // Keepalive cadence: two writes, then 16 idle cycles per KA plus the handshake cycle.
    k_rx_d = {2'b00, 1'b0, 7'h01, 32'h0000_0001};
    k_rx_v = 1'b1;
    tick();
    k_rx_d = {2'b00, 1'b0, 7'h02, 32'h0000_0002};
    tick();
    k_rx_v = 1'b0;
    repeat (15) tick();
    check("ka_before", {63'd0, k_tx_v}, 64'd0);
    tick();
    check("ka_first_v", {63'd0, k_tx_v}, 64'd1);
    check("ka_first_d", {30'd0, k_tx_d}, {30'd0, 34'h2_0000_0002});
    tick();
    check("ka_after", {63'd0, k_tx_v}, 64'd0);
    repeat (15) tick();
    check("ka_gap", {63'd0, k_tx_v}, 64'd0);
    tick();
    check("ka_second_v", {63'd0, k_tx_v}, 64'd1);
    check("no_ka_when_disabled", 64'(tx_v_cycles), 64'd0);

    // Write frame.
    send({2'b00, 1'b0, 7'h05, 32'h1234_5678});
    check("wr_we", {63'd0, bus_we}, 64'd1);
    check("wr_re", {63'd0, bus_re}, 64'd0);
    check("wr_addr", {57'd0, bus_addr}, 64'h05);
    check("wr_wdata", {32'd0, bus_wdata}, 64'h1234_5678);
    check("wr_frame_cnt", {48'd0, frame_cnt}, 64'd1);
    tick();
    check("wr_we_pulse", {63'd0, bus_we}, 64'd0);
    check("wr_no_tx", {63'd0, tx_v}, 64'd0);

    // Read, data 3 cycles after bus_re, immediate accept.
    send({2'b00, 1'b1, 7'h10, 32'h0});
    check("rd_re", {63'd0, bus_re}, 64'd1);
    check("rd_addr", {57'd0, bus_addr}, 64'h10);
    check("rd_frame_cnt", {48'd0, frame_cnt}, 64'd2);
    tick();
    check("rd_re_pulse", {63'd0, bus_re}, 64'd0);
    tick();
    tick();
    bus_rdata = 32'hCAFE_F00D; bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    check("rd_tx_v", {63'd0, tx_v}, 64'd1);
    check("rd_tx_d", {30'd0, tx_d}, {30'd0, 34'h0_CAFE_F00D});
    tick();
    check("rd_tx_one_cycle", {63'd0, tx_v}, 64'd0);

    // Same read with tx_rdy low for 5 cycles.
    tx_rdy = 1'b0;
    send({2'b00, 1'b1, 7'h10, 32'h0});
    tick();
    tick();
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_tx_v", {63'd0, tx_v}, 64'd1);
      check("hold_tx_d", {30'd0, tx_d}, {30'd0, 34'h0_CAFE_F00D});
      tick();
    end
    tx_rdy = 1'b1;
    check("hold_last_v", {63'd0, tx_v}, 64'd1);
    tick();
    check("hold_released", {63'd0, tx_v}, 64'd0);
    check("hold_tx_cycles", 64'(tx_v_cycles), 64'd7);

    // bus_rvalid coincident with bus_re is ignored.
    send({2'b00, 1'b1, 7'h11, 32'h0});
    bus_rdata = 32'h1111_1111; bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    check("same_cycle_ignored", {63'd0, tx_v}, 64'd0);
    bus_rdata = 32'h2222_2222; bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    check("same_cycle_later_d", {30'd0, tx_d}, {30'd0, 34'h0_2222_2222});
    tick();

    // Timeout: no bus_rvalid for READ_TIMEOUT=20 cycles.
    send({2'b00, 1'b1, 7'h12, 32'h0});
    repeat (20) tick();
    check("to_not_yet", {63'd0, tx_v}, 64'd0);
    tick();
    check("to_tx_v", {63'd0, tx_v}, 64'd1);
    check("to_tx_d", {30'd0, tx_d}, {30'd0, 34'h1_DEAD_BEEF});
    tick();
    check("to_done", {63'd0, tx_v}, 64'd0);

    // bus_rvalid on exactly the timeout cycle wins.
    send({2'b00, 1'b1, 7'h13, 32'h0});
    repeat (20) tick();
    bus_rdata = 32'h5A5A_5A5A; bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    check("to_edge_d", {30'd0, tx_d}, {30'd0, 34'h0_5A5A_5A5A});
    tick();

    // Bad frame header.
    send({2'b01, 1'b0, 7'h05, 32'h0000_FFFF});
    check("proto_cnt", {56'd0, proto_err}, 64'd1);
    check("proto_no_we", {62'd0, bus_we, bus_re}, 64'd0);
    check("proto_frame_cnt", {48'd0, frame_cnt}, 64'd6);
    tick();

    // Write while a read is pending.
    send({2'b00, 1'b1, 7'h14, 32'h0});
    rx_d = {2'b00, 1'b0, 7'h06, 32'hAAAA_5555};
    rx_v = 1'b1;
    tick();
    rx_v = 1'b0;
    check("ovr_cnt", {56'd0, overrun_err}, 64'd1);
    check("ovr_no_we", {63'd0, bus_we}, 64'd0);
    check("ovr_frame_cnt", {48'd0, frame_cnt}, 64'd7);
    bus_rdata = 32'h0000_0001; bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    check("ovr_read_done", {63'd0, tx_v}, 64'd1);
    tick();

    // 300 overruns while a response is held: counter saturates.
    tx_rdy = 1'b0;
    send({2'b00, 1'b1, 7'h15, 32'h0});
    tick();
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    rx_d = {2'b00, 1'b0, 7'h07, 32'h0};
    rx_v = 1'b1;
    repeat (300) tick();
    rx_v = 1'b0;
    check("ovr_saturate", {56'd0, overrun_err}, 64'hFF);
    check("ovr_sat_frame_cnt", {48'd0, frame_cnt}, 64'd8);
    tx_rdy = 1'b1;
    tick();
    tick();
    check("ovr_sat_released", {63'd0, tx_v}, 64'd0);

    // Async reset in the middle of READ_WAIT.
    send({2'b00, 1'b1, 7'h16, 32'h0});
    check("mid_rst_pre_re", {63'd0, bus_re}, 64'd1);
    r = 1'b0;
    #1;
    check("mid_rst_re", {63'd0, bus_re}, 64'd0);
    check("mid_rst_addr", {57'd0, bus_addr}, 64'd0);
    check("mid_rst_counts", {32'd0, frame_cnt, proto_err, overrun_err}, 64'd0);
    tick();
    tick();
    r = 1'b1;
    tick();
    bus_rdata = 32'h7777_7777; bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    check("mid_rst_no_tx", {63'd0, tx_v}, 64'd0);
    tick();
    check("mid_rst_no_tx_late", {63'd0, tx_v}, 64'd0);
    check("we_re_exclusive", 64'(excl_viol), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
